// File: rtl/video_sync_decoder_if.sv
// Signal bundle between the external sync separator, the sync decoder and the
// downstream row-trigger logic.
interface video_sync_decoder_if;
  logic       csync_in;
  logic       vsync_in;
  logic       odd_even_in;
  logic       hs_out;
  logic       odd_field_tri;
  logic       video_mode;
  logic       locked;
  logic [9:0] lines_per_frame;

  modport master (
    output csync_in, vsync_in, odd_even_in,
    input  hs_out, odd_field_tri, video_mode, locked, lines_per_frame
  );

  modport slave (
    input  csync_in, vsync_in, odd_even_in,
    output hs_out, odd_field_tri, video_mode, locked, lines_per_frame
  );
endinterface

// File: rtl/video_sync_decoder.sv
// Conditions separator csync/vsync/odd-even into a clean line sync, an odd-field
// start pulse and an auto-detected NTSC/PAL mode with lock status.
module video_sync_decoder #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned HOLDOFF  = 1200,
  parameter int unsigned HS_WIDTH = 127,
  parameter int unsigned TOL      = 3
) (
  input logic                   clk_in,
  input logic                   rst_n,
  video_sync_decoder_if.slave   bus
);

  typedef enum logic [1:0] {ClsNone, ClsNtsc, ClsPal} cls_e;

  localparam logic [3:0]  FiltLen  = 4'(FILT_LEN);
  localparam logic [3:0]  FiltLast = 4'(FILT_LEN - 1);
  localparam logic [10:0] Holdoff  = 11'(HOLDOFF);
  localparam logic [10:0] HsWidth  = 11'(HS_WIDTH);
  localparam logic [9:0]  NtscLo   = 10'(525 - TOL);
  localparam logic [9:0]  NtscHi   = 10'(525 + TOL);
  localparam logic [9:0]  PalLo    = 10'(625 - TOL);
  localparam logic [9:0]  PalHi    = 10'(625 + TOL);

  logic [1:0]  r_cs_sync;
  logic [3:0]  r_vs_sync;
  logic [1:0]  r_oe_sync;
  logic [3:0]  r_filt_cnt;
  logic        r_filt_edge;
  logic [10:0] r_holdoff;
  logic [10:0] r_width;
  logic        r_hs;
  logic [9:0]  r_line_cnt;
  logic [9:0]  r_lpf;
  logic        r_oft;
  logic        r_mode;
  logic        r_locked;
  cls_e        r_prev_cls;

  logic [3:0]  w_filt_cnt_d;
  logic        w_filt_hit;
  logic        w_accept;
  logic        w_field;
  cls_e        w_cls;

  // Extra vsync stages align the field pulse to the fourth edge after the first low sample.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_sync <= 2'b11;
      r_vs_sync <= 4'b1111;
      r_oe_sync <= 2'b00;
    end else begin
      r_cs_sync <= {r_cs_sync[0], bus.csync_in};
      r_vs_sync <= {r_vs_sync[2:0], bus.vsync_in};
      r_oe_sync <= {r_oe_sync[0], bus.odd_even_in};
    end
  end

  always_comb begin
    w_filt_cnt_d = r_filt_cnt;
    w_filt_hit   = 1'b0;
    if (r_cs_sync[1]) begin
      w_filt_cnt_d = 4'd0;
    end else if (r_filt_cnt != FiltLen) begin
      w_filt_cnt_d = r_filt_cnt + 4'd1;
      w_filt_hit   = (r_filt_cnt == FiltLast);
    end
  end

  assign w_accept = r_filt_edge && (r_holdoff == 11'd0);
  assign w_field  = r_vs_sync[3] && !r_vs_sync[2] && r_oe_sync[1];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_cnt  <= 4'd0;
      r_filt_edge <= 1'b0;
      r_holdoff   <= 11'd0;
      r_width     <= 11'd0;
      r_hs        <= 1'b1;
    end else begin
      r_filt_cnt  <= w_filt_cnt_d;
      r_filt_edge <= w_filt_hit;
      if (w_accept) begin
        r_holdoff <= Holdoff;
        r_width   <= HsWidth;
        r_hs      <= 1'b0;
      end else begin
        if (r_holdoff != 11'd0) r_holdoff <= r_holdoff - 11'd1;
        if (r_width != 11'd0) begin
          r_width <= r_width - 11'd1;
          if (r_width == 11'd1) r_hs <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_cls = ClsNone;
    if (r_line_cnt >= NtscLo && r_line_cnt <= NtscHi) begin
      w_cls = ClsNtsc;
    end else if (r_line_cnt >= PalLo && r_line_cnt <= PalHi) begin
      w_cls = ClsPal;
    end
  end

  // Status registers update on the edge that raises odd_field_tri.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_line_cnt <= 10'd0;
      r_lpf      <= 10'd0;
      r_oft      <= 1'b0;
      r_mode     <= 1'b0;
      r_locked   <= 1'b0;
      r_prev_cls <= ClsNone;
    end else begin
      r_oft <= w_field;
      if (w_field) begin
        r_line_cnt <= w_accept ? 10'd1 : 10'd0;
        r_lpf      <= r_line_cnt;
        r_prev_cls <= w_cls;
        if (w_cls == r_prev_cls && w_cls != ClsNone) begin
          r_mode   <= (w_cls == ClsPal);
          r_locked <= 1'b1;
        end else begin
          r_locked <= 1'b0;
        end
      end else if (w_accept && r_line_cnt != 10'h3FF) begin
        r_line_cnt <= r_line_cnt + 10'd1;
      end
    end
  end

  assign bus.hs_out          = r_hs;
  assign bus.odd_field_tri   = r_oft;
  assign bus.video_mode      = r_mode;
  assign bus.locked          = r_locked;
  assign bus.lines_per_frame = r_lpf;

endmodule

// File: tb/tb_video_sync_decoder.sv
// Scoreboard bench for video_sync_decoder; timing parameters are scaled down so
// full 525/625/700-line frames fit in a short run.
module tb_video_sync_decoder;
  localparam int unsigned FiltLen = 4;
  localparam int unsigned Holdoff = 12;
  localparam int unsigned HsWidth = 6;
  localparam int unsigned Tol     = 3;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  video_sync_decoder_if u_if ();

  video_sync_decoder #(
    .FILT_LEN (FiltLen),
    .HOLDOFF  (Holdoff),
    .HS_WIDTH (HsWidth),
    .TOL      (Tol)
  ) u_dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (u_if)
  );

  typedef struct {
    int cyc;
    int lpf;
    int mode;
    int locked;
  } fld_t;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   hs_q[$];
  fld_t fld_q[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents an hs_out fall or a field pulse.
  int hs_fall_cyc = 0;
  bit hs_in_pulse = 1'b0;
  int oft_run = 0;
  always @(negedge clk_in) begin
    if (!rst_n) begin
      hs_in_pulse = 1'b0;
      oft_run     = 0;
    end else begin
      if (!u_if.hs_out && !hs_in_pulse) begin
        hs_in_pulse = 1'b1;
        hs_fall_cyc = cyc;
        if (hs_q.size() == 0) check("hs_unexpected", cyc, -1);
        else check("hs_fall_cycle", cyc, hs_q.pop_front());
      end else if (u_if.hs_out && hs_in_pulse) begin
        hs_in_pulse = 1'b0;
        check("hs_width", cyc - hs_fall_cyc, HsWidth);
      end
      if (u_if.odd_field_tri) begin
        oft_run++;
        if (oft_run > 1) begin
          check("oft_width", oft_run, 1);
        end else if (fld_q.size() == 0) begin
          check("oft_unexpected", cyc, -1);
        end else begin
          fld_t e;
          e = fld_q.pop_front();
          check("oft_cycle", cyc, e.cyc);
          check("lines_per_frame", int'(u_if.lines_per_frame), e.lpf);
          check("video_mode", int'(u_if.video_mode), e.mode);
          check("locked", int'(u_if.locked), e.locked);
        end
      end else begin
        oft_run = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Low for `low` samples then high; total period low+high clocks.
  task automatic csync_pulse(input int low, input int high, input bit exp_hs);
    @(negedge clk_in);
    if (exp_hs) hs_q.push_back(cyc + 1 + 2 + FiltLen);
    u_if.csync_in = 1'b0;
    repeat (low) @(negedge clk_in);
    u_if.csync_in = 1'b1;
    repeat (high - 1) @(negedge clk_in);
  endtask

  task automatic field(input bit odd, input bit exp_pulse, input int lpf, input int mode,
                       input int locked);
    fld_t e;
    @(negedge clk_in);
    u_if.odd_even_in = odd;
    idle(3);
    @(negedge clk_in);
    if (exp_pulse) begin
      e.cyc    = cyc + 1 + 3;
      e.lpf    = lpf;
      e.mode   = mode;
      e.locked = locked;
      fld_q.push_back(e);
    end
    u_if.vsync_in = 1'b0;
    idle(8);
    u_if.vsync_in = 1'b1;
    idle(8);
  endtask

  task automatic frame(input int n, input int mode, input int locked);
    repeat (n) csync_pulse(6, 10, 1'b1);
    idle(4);
    field(1'b1, 1'b1, n, mode, locked);
  endtask

  initial begin
    u_if.csync_in    = 1'b1;
    u_if.vsync_in    = 1'b1;
    u_if.odd_even_in = 1'b0;
    idle(3);
    check("rst_hs_out", int'(u_if.hs_out), 1);
    check("rst_odd_field_tri", int'(u_if.odd_field_tri), 0);
    check("rst_video_mode", int'(u_if.video_mode), 0);
    check("rst_locked", int'(u_if.locked), 0);
    check("rst_lines_per_frame", int'(u_if.lines_per_frame), 0);
    rst_n = 1'b1;
    idle(5);

    // Glitches are rejected; a 6-clock pulse gives one line sync.
    repeat (3) csync_pulse(3, 10, 1'b0);
    csync_pulse(6, 30, 1'b1);

    // Half-line pulses: only every other one is accepted.
    for (int k = 0; k < 12; k++) csync_pulse(5, 3, (k % 2) == 0);
    idle(20);

    // 7 lines counted so far; even-field vsync gives no pulse.
    field(1'b1, 1'b1, 7, 0, 0);
    field(1'b0, 1'b0, 0, 0, 0);

    frame(625, 0, 0);
    frame(625, 1, 1);
    frame(625, 1, 1);
    frame(525, 1, 0);
    frame(525, 0, 1);
    frame(700, 0, 0);

    // Reset in the middle of an hs_out low pulse.
    @(negedge clk_in);
    hs_q.push_back(cyc + 1 + 2 + FiltLen);
    u_if.csync_in = 1'b0;
    repeat (6) @(negedge clk_in);
    u_if.csync_in = 1'b1;
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_hs_out", int'(u_if.hs_out), 1);
    check("rst_mid_lines_per_frame", int'(u_if.lines_per_frame), 0);
    check("rst_mid_locked", int'(u_if.locked), 0);
    idle(5);
    rst_n = 1'b1;
    idle(5);
    frame(10, 0, 0);

    idle(30);
    check("hs_expect_left", hs_q.size(), 0);
    check("fld_expect_left", fld_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_sync_decoder.md
# video_sync_decoder

Front-end sync stage feeding the row-trigger logic. It conditions the composite-sync, vertical-sync and odd/even outputs of the external video sync separator into four signals. `hs_out` is a clean line-rate sync with equalizing and serration pulses removed. `odd_field_tri` is a one-cycle odd-field start pulse. `video_mode` is NTSC/PAL, auto-detected from lines per frame. These are exactly the signals the downstream row-trigger counter consumes.

## Interface
- `FILT_LEN`, 4: consecutive low samples required to accept a csync falling edge (1..15).
- `HOLDOFF`, 1200: clocks after an accepted line sync during which further csync edges are ignored (11-bit, about 0.7 line at 27 MHz).
- `HS_WIDTH`, 127: low width of `hs_out` in clocks (must be < `HOLDOFF`).
- `TOL`, 3: ± line-count tolerance for standard classification.

Ports:
- `clk_in` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `csync_in` input 1: composite sync, active low, asynchronous to `clk_in`.
- `vsync_in` input 1: vertical sync, active low, asynchronous.
- `odd_even_in` input 1: field flag from the separator; 1 = odd field. Valid at the `vsync_in` falling edge.
- `hs_out` output 1: line sync, idle high, low pulse of `HS_WIDTH` clocks per accepted line.
- `odd_field_tri` output 1: single-cycle high pulse at the start of each odd field.
- `video_mode` output 1: 0 = NTSC (525 lines), 1 = PAL (625 lines).
- `locked` output 1: high while the last two frames both classified as the current `video_mode`.
- `lines_per_frame` output 10: line count of the last completed frame, saturating at 1023.

## Operation
- **Input synchronization.** Each of the three inputs passes through a 2-FF synchronizer. All logic below uses the synchronized values.
- **Csync glitch filter.**
  - A 4-bit counter increments while synced csync is 0 and clears to 0 while it is 1.
  - A filtered edge is asserted in the cycle the counter reaches `FILT_LEN`.
  - The counter holds at `FILT_LEN` while csync stays low, so there is one edge per low pulse.
- **Line sync generation.**
  - The 11-bit holdoff counter is idle at 0.
  - A filtered edge with holdoff == 0 is accepted. On acceptance, holdoff loads `HOLDOFF`, the width counter loads `HS_WIDTH`, and `hs_out` goes 0.
  - Holdoff decrements to 0. Filtered edges while holdoff ≠ 0 are discarded; these are the half-line equalizing and serration pulses.
  - `hs_out` returns to 1 when the width counter expires.
- **Field pulse.**
  - A falling edge of synced vsync with synced odd/even = 1 drives `odd_field_tri` = 1 for exactly one cycle.
  - A falling edge with odd/even = 0 produces no pulse.
- **Line counter.**
  - A 10-bit counter increments on each accepted line sync and saturates at 1023.
  - On an `odd_field_tri` pulse:
    - `lines_per_frame` ← the current count.
    - The count resets to 0, or to 1 if an accepted line sync coincides in the same cycle.
    - Classification runs.
- **Classification**, applied to the captured count:
  - Count in 525±`TOL` → NTSC.
  - Count in 625±`TOL` → PAL.
  - Anything else → NONE.
  - The previous class is held in a register, reset value NONE.
  - Class equal to the previous class and not NONE: `video_mode` ← class, `locked` ← 1.
  - Class differs from the previous class, or is NONE: `locked` ← 0 and `video_mode` is held.
  - In all cases the previous class ← the current class.
- **Reset.** `rst_n` low at any time, including mid-pulse, clears all counters. Reset values: `hs_out` = 1, `odd_field_tri` = 0, `video_mode` = 0, `locked` = 0, `lines_per_frame` = 0, previous class = NONE. Partially counted frames are discarded.

## Timing
- **Line sync latency.** `csync_in` first sampled low at edge N, held low for at least `FILT_LEN`+2 clocks → `hs_out` falls at edge N+2+`FILT_LEN`, if holdoff is 0.
- **Line sync width.** `hs_out` stays low for exactly `HS_WIDTH` cycles, independent of `csync_in` width.
- **Field pulse latency.** `vsync_in` first sampled low at edge N → `odd_field_tri` high for the cycle following edge N+3.
- **Status update.** `lines_per_frame`, `video_mode` and `locked` update on the same edge that `odd_field_tri` rises, so they are visible together with the pulse.
- **Re-arm.** A new line sync can be accepted `HOLDOFF`+1 cycles after the previous acceptance.
- **First frame after reset.** The first odd-field pulse after reset never asserts `locked`, because the previous class is still NONE.

## Test plan
- **Glitch rejection.**
  - Stimulus: csync low pulses of 3 clocks.
  - Required: `hs_out` stays 1.
  - Stimulus: a 6-clock low pulse.
  - Required: one 127-clock low on `hs_out`, falling 6 clocks after the first low sample.
- **Equalizing suppression.**
  - Stimulus: csync pulses every 864 clocks (half line) for 12 pulses.
  - Required: exactly 6 `hs_out` pulses, spaced 1728 clocks apart.
- **Field pulse.**
  - Stimulus: vsync falls with odd_even = 1, then with odd_even = 0.
  - Required: one 1-cycle `odd_field_tri` at 3 clocks latency for the first, none for the second.
- **PAL lock.**
  - Stimulus: three frames of 625 lines, odd fields only triggering.
  - Required: `lines_per_frame` = 625 each time; `video_mode` = 1 and `locked` = 1 from the second pulse.
- **Standard switch.**
  - Stimulus: after PAL lock, frames of 525, 525, then 700 lines.
  - Required:
    - First 525 frame: `locked` = 0, `video_mode` = 1.
    - Second 525 frame: `video_mode` = 0, `locked` = 1.
    - 700 frame: `locked` = 0, `video_mode` = 0.
- **Reset mid-line.**
  - Stimulus: assert `rst_n` low during an `hs_out` low pulse.
  - Required: `hs_out` = 1 immediately (asynchronous). The next frame after release reports a fresh count with `locked` = 0.
